// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : keypad_pkg
//  Purpose : Shared types and helpers for the 4x4 keypad hex entry block.
//            Contents:
//              state_t        - scan/debounce/accept/hold states
//              KEYMAP         - hex code of each key, indexed [row][col]
//              next_col()     - column rotation 0->1->2->3->0
//              one_low()      - true when exactly one row line is pulled low
//              low_index()    - index of the single low row line
//  Rev     : 1.0  initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Packed as {row3,row2,row1,row0}; each row is {col3,col2,col1,col0}.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  localparam logic [3:0][3:0][3:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [1:0] next_col(input logic [1:0] c);
    return c + 2'd1;
  endfunction

  function automatic logic one_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    case (r)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module  : sync_2ff
//  Purpose : Two-flop synchronizer for a bus of independent asynchronous bits.
//  Ports   : clock      in   system clock
//            reset      in   synchronous, active-high
//            d          in   WIDTH  asynchronous input
//            q          out  WIDTH  synchronized output (2-cycle latency)
//  Rev     : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/keypad_hex_entry.sv
`default_nettype none
// ============================================================================
//  Module  : keypad_hex_entry
//  Purpose : Scans a 4x4 active-low matrix keypad, debounces presses and
//            releases, and shifts each accepted key's hex code into a 32-bit
//            entry register (newest digit in [3:0]).
//  Ports   : clock      in   1   system clock
//            reset      in   1   synchronous, active-high
//            rows       in   4   keypad rows, active-low, asynchronous
//            cols       out  4   keypad columns, active-low, one-hot-low
//            HEX_out    out  32  entry register
//            key_code   out  4   code of the last accepted key
//            key_valid  out  1   one-cycle pulse coincident with the update
//  Config  : KEYPAD_REPEAT_EN - when defined, a held key re-enters its code
//            every REPEAT_CNT cycles; otherwise one press gives one digit.
//  Rev     : 1.0  initial release
// ============================================================================
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 500000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [31:0] HEX_out,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 1) begin : g_bad_params
    $error("keypad_hex_entry: parameter out of range");
  end

  // One timer serves the column dwell, press debounce and release debounce.
  localparam int TMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rs;
  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    col, col_nxt;
  logic [1:0]    row, row_nxt;
  logic [3:0]    pat, pat_nxt;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rep, rep_nxt;
`endif

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_rows_sync (
    .clock (clock),
    .reset (reset),
    .d     (rows),
    .q     (rs)
  );

  assign cols = ~(4'b0001 << col);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SCAN;
      timer <= '0;
      col   <= 2'd0;
      row   <= 2'd0;
      pat   <= 4'hF;
`ifdef KEYPAD_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      pat   <= pat_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep   <= rep_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    col_nxt   = col;
    row_nxt   = row;
    pat_nxt   = pat;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt   = rep;
`endif
    case (state)
      SCAN: begin
        if (timer == SCAN_LAST) begin
          timer_nxt = '0;
          if (one_low(rs)) begin
            // Column stays put so the debounce watches the same key.
            pat_nxt   = rs;
            row_nxt   = low_index(rs);
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = next_col(col);
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs == pat) begin
          if (timer == DEB_LAST) begin
            timer_nxt = '0;
            state_nxt = ACCEPT;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end else begin
          timer_nxt = '0;
          col_nxt   = next_col(col);
          state_nxt = SCAN;
        end
      end
      ACCEPT: begin
        timer_nxt = '0;
        state_nxt = HOLD;
`ifdef KEYPAD_REPEAT_EN
        rep_nxt   = '0;
`endif
      end
      HOLD: begin
        // Release must be a full all-high run; any low bit restarts it.
        if (rs == 4'hF) begin
          if (timer == DEB_LAST) begin
            timer_nxt = '0;
            col_nxt   = 2'd0;
            state_nxt = SCAN;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end else begin
          timer_nxt = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (rs == pat) begin
          if (rep == REP_LAST) begin
            rep_nxt   = '0;
            state_nxt = ACCEPT;
          end else begin
            rep_nxt = rep + RW'(1);
          end
        end else begin
          rep_nxt = '0;
        end
`endif
      end
      default: begin
        timer_nxt = '0;
        state_nxt = SCAN;
      end
    endcase
  end

  // Registered so key_valid lands in the same cycle as the visible update.
  always_ff @(posedge clock) begin
    if (reset) begin
      HEX_out   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else if (state == ACCEPT) begin
      HEX_out   <= {HEX_out[27:0], KEYMAP[row][col]};
      key_code  <= KEYMAP[row][col];
      key_valid <= 1'b1;
    end else begin
      key_valid <= 1'b0;
    end
  end

endmodule : keypad_hex_entry
`default_nettype wire
